// File: rtl/booth_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_divider_seq
//  Description : Multi-cycle signed integer divider. Restoring shift-subtract
//                on operand magnitudes (one quotient bit per clock) followed
//                by a sign-fixup cycle. Result Z = {remainder, quotient}.
//                Optional macro DIV_BY_ZERO_DETECT_EN: short-circuits b==0
//                into a 2-edge operation that flags div_by_zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   Z
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    // r_dvd starts as |a| and is progressively replaced by quotient bits.
    logic [WIDTH-1:0]     r_dvd;
    logic [WIDTH-1:0]     r_dvs;
    // The remainder is always below |b| <= 2^(WIDTH-1), so WIDTH bits hold it;
    // the extra (WIDTH+1)th bit only exists transiently in w_shift.
    logic [WIDTH-1:0]     r_rem;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_sign_q;
    logic                 r_sign_r;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_z;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_q_fix;
    logic [WIDTH-1:0]     w_r_fix;

`ifdef DIV_BY_ZERO_DETECT_EN
    logic                 r_zero;
    logic                 r_dbz;
    logic                 w_b_zero;
    logic [WIDTH-1:0]     w_a_back;

    assign w_b_zero = (b == '0);
    // |a| was never shifted on the zero path, so re-applying the sign gives a.
    assign w_a_back = r_sign_r ? (WIDTH'(0) - r_dvd) : r_dvd;
    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

    // Magnitudes wrap naturally: |-2^(WIDTH-1)| stays 2^(WIDTH-1) unsigned.
    assign w_abs_a = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
    assign w_abs_b = b[WIDTH-1] ? (WIDTH'(0) - b) : b;

    // One restoring step: shift next dividend bit into the remainder, trial-subtract.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

    // Sign fixup: quotient negated when operand signs differ, remainder follows a.
    assign w_q_fix = r_sign_q ? (WIDTH'(0) - r_dvd) : r_dvd;
    assign w_r_fix = r_sign_r ? (WIDTH'(0) - r_rem) : r_rem;

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign Z    = r_z;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_BY_ZERO_DETECT_EN
                    if (w_b_zero) begin
                        w_next = S_FIX;
                    end else begin
                        w_next = S_RUN;
                    end
`else
                    w_next = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_done   <= 1'b0;
            r_z      <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
            r_zero   <= 1'b0;
            r_dbz    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd    <= w_abs_a;
                        r_dvs    <= w_abs_b;
                        r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_sign_r <= a[WIDTH-1];
                        r_rem    <= '0;
                        r_cnt    <= c_cnt_w'(WIDTH - 1);
`ifdef DIV_BY_ZERO_DETECT_EN
                        r_zero   <= w_b_zero;
`endif
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                end
                S_FIX: begin
                    r_done <= 1'b1;
`ifdef DIV_BY_ZERO_DETECT_EN
                    r_dbz  <= r_zero;
                    if (r_zero) begin
                        r_z <= {w_a_back, {WIDTH{1'b1}}};
                    end else begin
                        r_z <= {w_r_fix, w_q_fix};
                    end
`else
                    r_z    <= {w_r_fix, w_q_fix};
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_divider_seq
//  Description : Scoreboard bench for booth_divider_seq (WIDTH=32). Stimulus
//                pushes hand-computed results; a monitor pops on each done.
//                Honors DIV_BY_ZERO_DETECT_EN for the b==0 expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_divider_seq;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic            clock;
    logic            reset_n;
    logic            start;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [2*W-1:0]  Z;

    typedef struct {
        logic [2*W-1:0] z;
        logic           dbz;
        int             due;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   s_cyc;

    booth_divider_seq #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .Z           (Z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [W-1:0] recon;
                mon_e = sb.pop_front();
                chk("Z", Z, mon_e.z);
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, mon_e.dbz});
                chk("latency", 64'(cyc), 64'(mon_e.due));
                recon = Z[W-1:0] * mon_e.b + Z[2*W-1:W];
                chk("identity", {32'd0, recon}, {32'd0, mon_e.a});
            end
        end
    end

    // Call at a negedge; applies start for exactly one posedge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [2*W-1:0] ez, input logic edbz, input int lat);
        exp_t e;
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clock);
        #1;
        s_cyc = cyc;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        e.z = ez; e.dbz = edbz; e.due = s_cyc + lat; e.a = ia; e.b = ib;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (done !== 1'b1 && n < 60);
        if (done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [2*W-1:0] ez, input logic edbz, input int lat);
        @(negedge clock);
        issue(ia, ib, ez, edbz, lat);
        wait_done();
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
        chk("rst_Z",    Z, 64'd0);
        reset_n = 1'b1;

        // 100 / 7 with busy window checks
        @(negedge clock);
        issue(32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, LAT);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        repeat (33) @(negedge clock);
        chk("busy_last_cycle", {63'd0, busy}, 64'd1);
        chk("done_early", {63'd0, done}, 64'd0);
        wait_done();
        chk("busy_at_done", {63'd0, busy}, 64'd0);

        // Sign combinations
        run_op(-32'sd100, 32'd7,  {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0, LAT);
        run_op(32'd100, -32'sd7,  {32'd2,         32'hFFFF_FFF2}, 1'b0, LAT);
        run_op(-32'sd100, -32'sd7,{32'hFFFF_FFFE, 32'd14},        1'b0, LAT);

        // Extremes
        run_op(32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, LAT);
        run_op(32'h8000_0000, 32'd1,         {32'd0, 32'h8000_0000}, 1'b0, LAT);
        run_op(32'd5, 32'd9,                 {32'd5, 32'd0},         1'b0, LAT);

        // Start during busy is ignored
        @(negedge clock);
        issue(32'd77, 32'd5, {32'd2, 32'd15}, 1'b0, LAT);
        repeat (10) @(negedge clock);
        start = 1'b1; a = 32'd1; b = 32'd1;
        @(negedge clock);
        start = 1'b0;
        wait_done();

        // Back-to-back: new start in the done cycle
        @(negedge clock);
        issue(32'd20, 32'd6, {32'd2, 32'd3}, 1'b0, LAT);
        wait_done();
        issue(32'd9, 32'd2, {32'd1, 32'd4}, 1'b0, LAT);
        wait_done();

        // Reset mid-operation
        @(negedge clock);
        issue(32'd1000, 32'd3, {32'd1, 32'd333}, 1'b0, LAT);
        repeat (15) @(negedge clock);
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_Z",    Z, 64'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        run_op(32'd1000, 32'd3, {32'd1, 32'd333}, 1'b0, LAT);

        // Divide by zero
`ifdef DIV_BY_ZERO_DETECT_EN
        run_op(-32'sd6, 32'd0, {32'hFFFF_FFFA, 32'hFFFF_FFFF}, 1'b1, 1);
        run_op(32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, LAT);
`else
        run_op(-32'sd6, 32'd0, {32'hFFFF_FFFA, 32'd1}, 1'b0, LAT);
`endif

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
